zap_copro_dispatch: RTL and testbench
=====================================

Name: zap_copro_dispatch

Overview:
- Sits between the predecode coprocessor stage and N attached coprocessors (CP15 and others). Shares one low-bandwidth coprocessor word/dav channel among them.
- Routes each request to the slave whose CP number matches word[11:8], sequences the req/done handshake, and returns a single done to predecode.
- Converts unmapped CP numbers and unresponsive slaves into a done plus undefined-instruction indication, so predecode never hangs.

Parameters:
- NUM_CP, 2, number of attached coprocessor slots (1..8).
- CP_MAP, {4'd14,4'd15}, packed 4-bit CP number per slot; slot i = CP_MAP[4i+3:4i].
- TIMEOUT, 64, max WAIT cycles before abort (>=2).

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous active-high reset
- i_copro_dav  in  1  request valid from predecode; level, held until done is seen
- i_copro_word  in  32  full coprocessor instruction
- o_copro_done  out  1  one-cycle completion pulse to predecode
- o_copro_undef  out  1  one-cycle pulse coincident with o_copro_done when unmapped or timed out
- o_cp_dav  out  NUM_CP  one-hot request to slots
- o_cp_word  out  32  latched instruction broadcast to all slots
- i_cp_done  in  NUM_CP  per-slot completion
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset. All outputs are registered.
- Reset values: state=IDLE; o_cp_dav=0; o_cp_word=0; o_copro_done=0; o_copro_undef=0; o_busy=0; counter=0; grant=0.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE with i_copro_dav=1:
  - Compare word[11:8] against every CP_MAP slot. Lowest matching index wins.
  - On a match: latch word into o_cp_word, set o_cp_dav[g]=1 next cycle, clear counter, go to WAIT. Request latency is 1 cycle.
  - On no match: next cycle o_copro_done=1 and o_copro_undef=1 for one cycle, go to DRAIN. No o_cp_dav is raised.
- WAIT:
  - o_cp_dav[g] and o_cp_word are held stable. Counter increments each cycle.
  - i_cp_done[g]=1: next cycle o_cp_dav=0 and o_copro_done=1 for one cycle; go to DRAIN. Done latency is 1 cycle.
  - i_cp_done bits of non-granted slots are ignored.
  - Counter reaches TIMEOUT-1 without done: next cycle o_cp_dav=0, o_copro_done=1, o_copro_undef=1; go to DRAIN.
  - Done and timeout in the same cycle: done wins, undef=0.
  - i_copro_dav=0 (predecode flushed): abort. Next cycle o_cp_dav=0, no done pulse, go to IDLE. This takes priority over a simultaneous i_cp_done or timeout.
- DRAIN:
  - No new request is accepted until i_copro_dav=0 has been seen. This covers predecode holding dav across its own stall.
  - When i_copro_dav=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after IDLE is re-entered.
- Counter width: clog2(TIMEOUT+1). It saturates and cannot wrap.
- o_copro_done is never asserted on consecutive cycles.
- At most one o_cp_dav bit is high at any time.
- Reset mid-operation: all state is cleared immediately. o_cp_dav drops on the cycle after reset is sampled. A slot's pending done arriving afterwards is ignored.

Test Plan:
1. Reset, then dav=1 with word=32'hEE01_0F10 (CP15) -> o_cp_dav=2'b10 one cycle later, o_cp_word=32'hEE01_0F10. i_cp_done[1] pulsed 3 cycles later -> o_copro_done=1 exactly one cycle, o_cp_dav=0, undef=0. Hold dav 2 more cycles -> no second done; IDLE after dav drops.
2. word[11:8]=4'd14 -> o_cp_dav=2'b01. Pulse i_cp_done[1] (wrong slot) -> ignored. Then i_cp_done[0] -> done pulse.
3. word[11:8]=4'd3 (unmapped) -> o_cp_dav stays 0; the cycle after dav, o_copro_done=1 and o_copro_undef=1 for one cycle.
4. CP15 request with no slave response -> after TIMEOUT=64 WAIT cycles, o_cp_dav=0 and done=undef=1 for one cycle.
5. Flush: drop i_copro_dav during WAIT in the same cycle as i_cp_done[1]=1 -> no o_copro_done, o_cp_dav=0 next cycle, state IDLE; the following request is accepted normally.
6. Assert i_reset during WAIT -> all outputs 0 the next cycle, o_busy=0; a late i_cp_done produces no done.

Source files
------------

// File: rtl/zap_copro_dispatch.sv
// zap_copro_dispatch: routes predecode coprocessor requests to the slot whose
// CP number matches word[11:8], sequences the per-slot req/done handshake and
// returns one done pulse. Unmapped CP numbers and slots that never answer
// complete with an undefined-instruction flag, so predecode can never hang.
module zap_copro_dispatch #(
  parameter int                  NUM_CP  = 2,
  parameter logic [4*NUM_CP-1:0] CP_MAP  = {4'd14, 4'd15},
  parameter int                  TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_copro_dav,
  input  logic [31:0]       i_copro_word,
  output logic              o_copro_done,
  output logic              o_copro_undef,
  output logic [NUM_CP-1:0] o_cp_dav,
  output logic [31:0]       o_cp_word,
  input  logic [NUM_CP-1:0] i_cp_done,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int GNT_W = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t            r_state, w_state_next;
  logic [NUM_CP-1:0] r_cp_dav, w_cp_dav_next;
  logic [31:0]       r_cp_word, w_cp_word_next;
  logic              r_done, w_done_next;
  logic              r_undef, w_undef_next;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [GNT_W-1:0]  r_grant, w_grant_next;

  logic [NUM_CP-1:0] w_hit;
  logic              w_any_hit;
  logic [GNT_W-1:0]  w_sel;

  // Per-slot CP number comparison against the incoming instruction.
  generate
    for (genvar gi = 0; gi < NUM_CP; gi++) begin : g_match
      assign w_hit[gi] = (i_copro_word[11:8] == CP_MAP[4*gi +: 4]);
    end
  endgenerate

  // Priority encode the hits; scanning downward lets the lowest index win.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_CP - 1; i >= 0; i--) begin
      if (w_hit[i]) w_sel = GNT_W'(i);
    end
  end

  assign w_any_hit = |w_hit;

  // Next-state and next-output decode for the dispatch sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_cp_dav_next  = r_cp_dav;
    w_cp_word_next = r_cp_word;
    w_done_next    = 1'b0;
    w_undef_next   = 1'b0;
    w_cnt_next     = r_cnt;
    w_grant_next   = r_grant;
    case (r_state)
      IDLE: begin
        if (i_copro_dav) begin
          if (w_any_hit) begin
            w_cp_word_next = i_copro_word;
            w_cp_dav_next  = NUM_CP'(1) << w_sel;
            w_grant_next   = w_sel;
            w_cnt_next     = '0;
            w_state_next   = WAIT;
          end else begin
            w_done_next  = 1'b1;
            w_undef_next = 1'b1;
            w_state_next = DRAIN;
          end
        end
      end
      WAIT: begin
        // A flush outranks both completion and timeout: predecode has
        // already discarded the instruction, so no done is returned.
        if (!i_copro_dav) begin
          w_cp_dav_next = '0;
          w_state_next  = IDLE;
        end else if (i_cp_done[r_grant]) begin
          w_cp_dav_next = '0;
          w_done_next   = 1'b1;
          w_state_next  = DRAIN;
        end else if (r_cnt == CNT_LAST) begin
          w_cp_dav_next = '0;
          w_done_next   = 1'b1;
          w_undef_next  = 1'b1;
          w_state_next  = DRAIN;
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // Predecode may keep dav high across its own stall; wait for it to
        // drop so the same instruction is never dispatched twice.
        if (!i_copro_dav) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cp_dav  <= '0;
      r_cp_word <= '0;
      r_done    <= 1'b0;
      r_undef   <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_grant   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cp_dav  <= w_cp_dav_next;
      r_cp_word <= w_cp_word_next;
      r_done    <= w_done_next;
      r_undef   <= w_undef_next;
      r_busy    <= (w_state_next != IDLE);
      r_cnt     <= w_cnt_next;
      r_grant   <= w_grant_next;
    end
  end

  assign o_copro_done  = r_done;
  assign o_copro_undef = r_undef;
  assign o_cp_dav      = r_cp_dav;
  assign o_cp_word     = r_cp_word;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// Directed bench for zap_copro_dispatch: CP15/CP14 handshakes, wrong-slot
// done, unmapped CP, timeout, flush racing a done, and reset during WAIT.
module tb_zap_copro_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        copro_dav;
  logic [31:0] copro_word;
  logic        copro_done;
  logic        copro_undef;
  logic [1:0]  cp_dav;
  logic [31:0] cp_word;
  logic [1:0]  cp_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Slot 0 answers CP14, slot 1 answers CP15.
  zap_copro_dispatch #(
    .NUM_CP (2),
    .CP_MAP ({4'd15, 4'd14}),
    .TIMEOUT(64)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_copro_dav  (copro_dav),
    .i_copro_word (copro_word),
    .o_copro_done (copro_done),
    .o_copro_undef(copro_undef),
    .o_cp_dav     (cp_dav),
    .o_cp_word    (cp_word),
    .i_cp_done    (cp_done),
    .o_busy       (busy)
  );

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_dav, input logic e_done,
                         input logic e_undef, input logic e_busy);
    chk({tag, ".cp_dav"}, 32'(cp_dav), 32'(e_dav));
    chk({tag, ".done"},   32'(copro_done), 32'(e_done));
    chk({tag, ".undef"},  32'(copro_undef), 32'(e_undef));
    chk({tag, ".busy"},   32'(busy), 32'(e_busy));
  endtask

  initial begin
    reset = 1'b1; copro_dav = 1'b0; copro_word = '0; cp_done = '0;
    step(); step();
    reset = 1'b0;
    chk_all("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rst.cp_word", cp_word, 32'h0);

    // 1: CP15 request, done after 3 cycles, dav held through DRAIN.
    copro_dav = 1'b1; copro_word = 32'hEE01_0F10;
    step();
    chk_all("t1.req", 2'b10, 1'b0, 1'b0, 1'b1);
    chk("t1.cp_word", cp_word, 32'hEE01_0F10);
    copro_word = 32'h0;
    step();
    step();
    chk_all("t1.hold", 2'b10, 1'b0, 1'b0, 1'b1);
    chk("t1.word_hold", cp_word, 32'hEE01_0F10);
    cp_done = 2'b10;
    step();
    cp_done = 2'b00;
    chk_all("t1.done", 2'b00, 1'b1, 1'b0, 1'b1);
    step();
    chk_all("t1.drain1", 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("t1.drain2", 2'b00, 1'b0, 1'b0, 1'b1);
    copro_dav = 1'b0;
    step();
    chk_all("t1.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // 2: CP14 request, wrong-slot done ignored, then right slot.
    copro_dav = 1'b1; copro_word = 32'hEE01_0E10;
    step();
    chk_all("t2.req", 2'b01, 1'b0, 1'b0, 1'b1);
    cp_done = 2'b10;
    step();
    chk_all("t2.wrong", 2'b01, 1'b0, 1'b0, 1'b1);
    cp_done = 2'b01;
    step();
    cp_done = 2'b00;
    chk_all("t2.done", 2'b00, 1'b1, 1'b0, 1'b1);
    copro_dav = 1'b0;
    step();
    chk_all("t2.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // 3: unmapped CP3.
    copro_dav = 1'b1; copro_word = 32'hEE01_0310;
    step();
    chk_all("t3.undef", 2'b00, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("t3.drain", 2'b00, 1'b0, 1'b0, 1'b1);
    copro_dav = 1'b0;
    step();
    chk_all("t3.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // 4: CP15 with no response; 64 WAIT cycles then timeout.
    copro_dav = 1'b1; copro_word = 32'hEE01_0F10;
    step();
    for (int i = 0; i < 63; i++) step();
    chk_all("t4.last_wait", 2'b10, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("t4.timeout", 2'b00, 1'b1, 1'b1, 1'b1);
    copro_dav = 1'b0;
    step();
    chk_all("t4.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // 5: flush in the same cycle as a slot done, then a normal request.
    copro_dav = 1'b1; copro_word = 32'hEE01_0F10;
    step();
    step();
    copro_dav = 1'b0; cp_done = 2'b10;
    step();
    cp_done = 2'b00;
    chk_all("t5.flush", 2'b00, 1'b0, 1'b0, 1'b0);
    copro_dav = 1'b1; copro_word = 32'hEE01_0E10;
    step();
    chk_all("t5.req2", 2'b01, 1'b0, 1'b0, 1'b1);
    chk("t5.cp_word", cp_word, 32'hEE01_0E10);
    cp_done = 2'b01;
    step();
    cp_done = 2'b00;
    chk_all("t5.done2", 2'b00, 1'b1, 1'b0, 1'b1);
    copro_dav = 1'b0;
    step();

    // 6: reset during WAIT, late slot done afterwards.
    copro_dav = 1'b1; copro_word = 32'hEE01_0F10;
    step();
    chk_all("t6.req", 2'b10, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    chk_all("t6.rst", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("t6.cp_word", cp_word, 32'h0);
    reset = 1'b0; copro_dav = 1'b0; cp_done = 2'b10;
    step();
    cp_done = 2'b00;
    chk_all("t6.late", 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("t6.after", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
